// File: rtl/sram_port_arbiter_pkg.sv
// Shared defaults and port-index names for the SRAM port arbiter.
// Port 0 is the serial loader, the only master allowed during a LOCK session.
package sram_port_arbiter_pkg;

   localparam int DEF_NUM_PORTS         = 3;
   localparam int DEF_MEMORY_DATA_WIDTH = 8;
   localparam int DEF_MEMORY_ADDR_WIDTH = 9;
   localparam int DEF_MAX_BURST         = 4;
   localparam int DEF_RR_MODE           = 1;

   localparam int PORT_LOADER = 0;
   localparam int PORT_INSTR  = 1;
   localparam int PORT_DATA   = 2;

endpackage

// File: rtl/rr_priority_pick.sv
// One-hot pick of the first set request bit, searching upward from start
// and wrapping at N-1. A zero start gives fixed lowest-index priority.
module rr_priority_pick #(
   parameter int N  = 3,
   parameter int PW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] start,
   output logic [N-1:0]  gnt
);

   logic found;
   int   j;

   always_comb begin
      gnt   = '0;
      found = 1'b0;
      j     = 0;
      for (int i = 0; i < N; i++) begin
         j = int'(start) + i;
         if (j >= N) j = j - N;
         if (!found && req[PW'(j)]) begin
            gnt[PW'(j)] = 1'b1;
            found       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sram_port_arbiter.sv
// Single-port SRAM arbiter: one access per cycle, burst ownership with a
// fairness limit, and a loader LOCK that fences out the CPU ports.
module sram_port_arbiter
   import sram_port_arbiter_pkg::*;
#(
   parameter int NUM_PORTS         = DEF_NUM_PORTS,
   parameter int MEMORY_DATA_WIDTH = DEF_MEMORY_DATA_WIDTH,
   parameter int MEMORY_ADDR_WIDTH = DEF_MEMORY_ADDR_WIDTH,
   parameter int MAX_BURST         = DEF_MAX_BURST,
   parameter int RR_MODE           = DEF_RR_MODE
) (
   input  logic                                     CLK,
   input  logic                                     RST,
   input  logic                                     LOCK,
   input  logic [NUM_PORTS-1:0]                     REQ,
   input  logic [NUM_PORTS-1:0]                     WE,
   input  logic [NUM_PORTS*MEMORY_ADDR_WIDTH-1:0]   ADDR,
   input  logic [NUM_PORTS*MEMORY_DATA_WIDTH-1:0]   WDATA,
   output logic [NUM_PORTS-1:0]                     GNT,
   output logic [NUM_PORTS-1:0]                     RVLD,
   output logic [MEMORY_DATA_WIDTH-1:0]             RDATA,
   output logic                                     CEN_after_mux,
   output logic                                     WEN_after_mux,
   output logic [MEMORY_ADDR_WIDTH-1:0]             A_after_mux,
   output logic [MEMORY_DATA_WIDTH-1:0]             D_after_mux,
   input  logic [MEMORY_DATA_WIDTH-1:0]             Q_from_SRAM,
   output logic                                     BUSY
);

   localparam int AW = MEMORY_ADDR_WIDTH;
   localparam int DW = MEMORY_DATA_WIDTH;
   localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int BW = $clog2(MAX_BURST + 1);
   localparam logic [NUM_PORTS-1:0] LOADER_ONLY = NUM_PORTS'(1) << PORT_LOADER;

   logic                 lock_q;
   logic                 own_vld;
   logic [PW-1:0]        owner;
   logic [PW-1:0]        ptr;
   logic [BW-1:0]        bcnt;
   logic [NUM_PORTS-1:0] rvld_q;

   logic [NUM_PORTS-1:0] elig, own_bit, others, pick_req, pick_gnt;
   logic [PW-1:0]        start, gidx;
   logic                 keep, pass, any, we_sel;

   // LOCK is applied from the cycle after it is seen, so a beat already
   // granted in the LOCK cycle still completes.
   always_comb begin
      elig     = REQ & (lock_q ? LOADER_ONLY : '1);
      own_bit  = own_vld ? (NUM_PORTS'(1) << owner) : '0;
      keep     = |(elig & own_bit);
      others   = elig & ~own_bit;
      pass     = keep && (bcnt >= BW'(MAX_BURST)) && (|others);
      pick_req = keep ? others : elig;
   end

   assign start = (RR_MODE != 0) ? ptr : '0;

   rr_priority_pick #(.N(NUM_PORTS), .PW(PW)) u_pick (
      .req   (pick_req),
      .start (start),
      .gnt   (pick_gnt)
   );

   always_comb begin
      GNT         = '0;
      gidx        = '0;
      we_sel      = 1'b0;
      A_after_mux = '0;
      D_after_mux = '0;
      if (!RST) GNT = (keep && !pass) ? own_bit : pick_gnt;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (GNT[p]) begin
            gidx        = PW'(p);
            we_sel      = WE[p];
            A_after_mux = ADDR[p*AW +: AW];
            D_after_mux = WDATA[p*DW +: DW];
         end
      end
   end

   assign any           = |GNT;
   assign CEN_after_mux = !any;
   assign WEN_after_mux = !(any && we_sel);

   always_ff @(posedge CLK) begin
      if (RST) begin
         lock_q  <= 1'b0;
         own_vld <= 1'b0;
         owner   <= '0;
         ptr     <= '0;
         bcnt    <= '0;
         rvld_q  <= '0;
      end else begin
         lock_q <= LOCK;
         rvld_q <= (any && !we_sel) ? GNT : '0;
         // Loader grants under LOCK never form a burst nor move the pointer.
         if (lock_q || !any) begin
            own_vld <= 1'b0;
            bcnt    <= '0;
         end else if (own_vld && gidx == owner) begin
            if (bcnt != BW'(MAX_BURST)) bcnt <= bcnt + 1'b1;
         end else begin
            own_vld <= 1'b1;
            owner   <= gidx;
            bcnt    <= BW'(1);
            ptr     <= (gidx == PW'(NUM_PORTS - 1)) ? '0 : gidx + 1'b1;
         end
      end
   end

   assign RVLD  = RST ? '0 : rvld_q;
   assign RDATA = (|RVLD) ? Q_from_SRAM : '0;
   assign BUSY  = any || (|RVLD);

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench: two arbiters (MAX_BURST 4 and 1) share stimulus; a
// port-level reference model predicts each grant and read return.
module tb_sram_port_arbiter;

   localparam int NP = 3;
   localparam int AW = 9;
   localparam int DW = 8;

   typedef struct {
      int cyc;
      int port;
      int addr;
      int we;
      int data;
   } rec_t;

   logic              CLK = 1'b0;
   logic              RST = 1'b1;
   logic              LOCK = 1'b0;
   logic [NP-1:0]     REQ = '1;
   logic [NP-1:0]     WE = '0;
   logic [NP*AW-1:0]  ADDR = '0;
   logic [NP*DW-1:0]  WDATA = '0;

   logic [NP-1:0] gnt_w [2];
   logic [NP-1:0] rvld_w [2];
   logic [DW-1:0] rdata_w [2];
   logic [DW-1:0] d_w [2];
   logic [AW-1:0] a_w [2];
   logic          cen_w [2];
   logic          wen_w [2];
   logic          busy_w [2];

   int   cyc = 0;
   int   checks = 0;
   int   fails = 0;
   bit   started = 1'b0;

   rec_t gq [2][$];
   rec_t rq [2][$];

   int   m_owner [2];
   int   m_beats [2];
   int   m_ptr [2];
   bit   m_lock [2];
   logic [DW-1:0] mmem [2][512];

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   function automatic logic [DW-1:0] init_val(int i);
      if (i == 16) return 8'hA5;
      return DW'((i * 37 + 11) & 255);
   endfunction

   for (genvar k = 0; k < 2; k++) begin : g_inst
      logic [NP-1:0] gnt, rvld;
      logic [DW-1:0] rdata, d, q;
      logic [AW-1:0] a;
      logic          cen, wen, busy;
      logic [DW-1:0] sram [512];

      sram_port_arbiter #(.MAX_BURST(k == 0 ? 4 : 1)) dut (
         .CLK(CLK), .RST(RST), .LOCK(LOCK), .REQ(REQ), .WE(WE),
         .ADDR(ADDR), .WDATA(WDATA), .GNT(gnt), .RVLD(rvld), .RDATA(rdata),
         .CEN_after_mux(cen), .WEN_after_mux(wen), .A_after_mux(a),
         .D_after_mux(d), .Q_from_SRAM(q), .BUSY(busy)
      );

      initial begin
         q = '0;
         for (int i = 0; i < 512; i++) sram[i] = init_val(i);
      end

      always @(posedge CLK) begin
         if (!cen) begin
            if (!wen) sram[a] <= d;
            else q <= sram[a];
         end
      end

      assign gnt_w[k] = gnt;   assign rvld_w[k] = rvld;
      assign rdata_w[k] = rdata; assign d_w[k] = d;
      assign a_w[k] = a;       assign cen_w[k] = cen;
      assign wen_w[k] = wen;   assign busy_w[k] = busy;
   end

   task automatic chk(input string name, input int k, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s inst%0d cyc %0d: got %0h expected %0h", name, k, cyc, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int rr_search(int mask, int start);
      for (int i = 0; i < NP; i++) begin
         int p;
         p = (start + i) % NP;
         if (((mask >> p) & 1) != 0) return p;
      end
      return -1;
   endfunction

   function automatic int model_pick(int k);
      int el, o, others, mb;
      mb = (k == 0) ? 4 : 1;
      el = m_lock[k] ? int'(REQ[0]) : int'(REQ);
      o  = m_owner[k];
      if (o >= 0 && ((el >> o) & 1) != 0) begin
         others = el & ~(1 << o);
         if (m_beats[k] < mb || others == 0) return o;
         return rr_search(others, m_ptr[k]);
      end
      return rr_search(el, m_ptr[k]);
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_owner[k] = -1; m_beats[k] = 0; m_ptr[k] = 0; m_lock[k] = 1'b0;
      end
   endtask

   // Predict this cycle's responses, advance the model, then take the edge.
   task automatic step();
      for (int k = 0; k < 2; k++) begin
         int   g, mb;
         rec_t r;
         mb = (k == 0) ? 4 : 1;
         g  = model_pick(k);
         if (g >= 0) begin
            r.cyc = cyc; r.port = g; r.addr = int'(ADDR[g*AW +: AW]);
            r.we = int'(WE[g]); r.data = int'(WDATA[g*DW +: DW]);
            gq[k].push_back(r);
            if (WE[g]) mmem[k][r.addr] = DW'(r.data);
            else begin
               r.cyc = cyc + 1; r.data = int'(mmem[k][r.addr]);
               rq[k].push_back(r);
            end
         end
         if (m_lock[k] || g < 0) begin
            m_owner[k] = -1; m_beats[k] = 0;
         end else if (g == m_owner[k]) begin
            if (m_beats[k] < mb) m_beats[k]++;
         end else begin
            m_owner[k] = g; m_beats[k] = 1; m_ptr[k] = (g + 1) % NP;
         end
         m_lock[k] = LOCK;
      end
      @(posedge CLK); #1;
   endtask

   task automatic do_reset(input int n);
      RST = 1'b1;
      for (int k = 0; k < 2; k++) begin
         gq[k].delete(); rq[k].delete();
      end
      repeat (n) begin
         @(negedge CLK);
         for (int k = 0; k < 2; k++) begin
            chk("rst_gnt", k, gnt_w[k], 0);
            chk("rst_cen", k, cen_w[k], 1);
            chk("rst_wen", k, wen_w[k], 1);
            chk("rst_rvld", k, rvld_w[k], 0);
            chk("rst_busy", k, busy_w[k], 0);
            chk("rst_rdata", k, rdata_w[k], 0);
         end
         @(posedge CLK); #1;
      end
      RST = 1'b0;
      model_reset();
   endtask

   task automatic setp(input int p, input bit r, input bit w, input int a, input int d);
      REQ[p] = r; WE[p] = w;
      ADDR[p*AW +: AW] = AW'(a);
      WDATA[p*DW +: DW] = DW'(d);
   endtask

   task automatic idle(input int n);
      REQ = '0; WE = '0; LOCK = 1'b0;
      repeat (n) step();
   endtask

   // ---------------- monitor ----------------
   always @(negedge CLK) begin
      if (started && !RST) begin
         for (int k = 0; k < 2; k++) begin
            bit   has_g, has_r;
            rec_t r;
            while (gq[k].size() > 0 && gq[k][0].cyc < cyc) begin
               chk("gnt_missing_cyc", k, gq[k][0].cyc, cyc);
               void'(gq[k].pop_front());
            end
            while (rq[k].size() > 0 && rq[k][0].cyc < cyc) begin
               chk("rvld_missing_cyc", k, rq[k][0].cyc, cyc);
               void'(rq[k].pop_front());
            end
            has_g = gq[k].size() > 0 && gq[k][0].cyc == cyc;
            has_r = rq[k].size() > 0 && rq[k][0].cyc == cyc;
            chk("busy", k, busy_w[k], has_g || has_r);
            if (has_g) begin
               r = gq[k].pop_front();
               chk("gnt", k, gnt_w[k], 1 << r.port);
               chk("cen", k, cen_w[k], 0);
               chk("wen", k, wen_w[k], r.we == 0);
               chk("addr", k, a_w[k], r.addr);
               chk("wdata", k, d_w[k], r.data);
            end else begin
               chk("gnt_idle", k, gnt_w[k], 0);
               chk("cen_idle", k, cen_w[k], 1);
               chk("wen_idle", k, wen_w[k], 1);
               chk("addr_idle", k, a_w[k], 0);
               chk("d_idle", k, d_w[k], 0);
            end
            if (has_r) begin
               r = rq[k].pop_front();
               chk("rvld", k, rvld_w[k], 1 << r.port);
               chk("rdata", k, rdata_w[k], r.data);
            end else begin
               chk("rvld_idle", k, rvld_w[k], 0);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      for (int k = 0; k < 2; k++)
         for (int i = 0; i < 512; i++) mmem[k][i] = init_val(i);
      model_reset();
      @(posedge CLK); #1;
      do_reset(2);
      started = 1'b1;
      idle(1);

      // port 1 read of a preloaded word
      setp(1, 1, 0, 'h010, 0); step(); idle(2);

      // loader write to the top address, then CPU data read of it
      setp(0, 1, 1, 'h1FF, 'h3C); step(); idle(1);
      setp(2, 1, 0, 'h1FF, 0); step(); idle(2);

      // all ports held: rotation (burst 1) vs bursting (burst 4)
      setp(0, 1, 0, 3, 0); setp(1, 1, 0, 4, 0); setp(2, 1, 0, 5, 0);
      repeat (8) step();
      idle(2);

      // port 2 owns first, port 1 joins
      setp(2, 1, 0, 7, 0); step();
      setp(1, 1, 0, 8, 0); repeat (7) step();

      // LOCK mid-burst; loader requests too
      setp(0, 1, 1, 9, 'h77); LOCK = 1'b1; repeat (4) step();
      LOCK = 1'b0; repeat (4) step();
      idle(1);

      // reset with a read in flight
      setp(1, 1, 0, 'h010, 0); step();
      REQ = '1; do_reset(1);
      idle(2);

      // randomized traffic
      repeat (600) begin
         for (int p = 0; p < NP; p++) begin
            if ($urandom_range(0, 99) < 30) begin
               REQ[p] = ~REQ[p];
               if (REQ[p]) setp(p, 1, $urandom_range(0, 1) == 1,
                                $urandom_range(0, 15), $urandom_range(0, 255));
            end else if ($urandom_range(0, 99) < 20) begin
               setp(p, REQ[p], $urandom_range(0, 1) == 1,
                    $urandom_range(0, 3) == 0 ? $urandom_range(0, 511) : $urandom_range(0, 15),
                    $urandom_range(0, 255));
            end
         end
         if ($urandom_range(0, 99) < 4) LOCK = ~LOCK;
         step();
      end
      idle(3);

      @(negedge CLK);
      for (int k = 0; k < 2; k++) begin
         chk("gq_left", k, gq[k].size(), 0);
         chk("rq_left", k, rq[k].size(), 0);
      end
      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
